// File: rtl/hdr_mode_scheduler_pkg.sv
// Shared video-ctrl definitions for the HDR/non-HDR path scheduler:
// FSM state encoding and cfg_mode codes.
package hdr_mode_scheduler_pkg;

    localparam logic [1:0] ST_NHDR_ACTIVE = 2'd0;
    localparam logic [1:0] ST_HDR_WARMUP  = 2'd1;
    localparam logic [1:0] ST_HDR_ACTIVE  = 2'd2;
    localparam logic [1:0] ST_HDR_DRAIN   = 2'd3;

    typedef enum logic [1:0] {
        NHDR_ACTIVE = ST_NHDR_ACTIVE,
        HDR_WARMUP  = ST_HDR_WARMUP,
        HDR_ACTIVE  = ST_HDR_ACTIVE,
        HDR_DRAIN   = ST_HDR_DRAIN
    } state_t;

    localparam logic [1:0] MODE_NHDR = 2'd0;
    localparam logic [1:0] MODE_HDR  = 2'd1;
    localparam logic [1:0] MODE_ALT  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    localparam int FRM_W = 8;

endpackage

// File: rtl/hdr_mode_scheduler_if.sv
// Config, video-sync and status signals between the register bank / video
// paths (master) and the scheduler (slave).
interface hdr_mode_scheduler_if;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_alt_period;
    logic       cfg_err_clr;
    logic       hdr_ready;
    logic       hdr_vs_in;
    logic       out_vs_in;
    logic       hdr_en;
    logic       hdr_sel;
    logic       busy;
    logic       switch_done;
    logic       err_timeout;

    modport master (
        output cfg_mode, cfg_alt_period, cfg_err_clr, hdr_ready, hdr_vs_in, out_vs_in,
        input  hdr_en, hdr_sel, busy, switch_done, err_timeout
    );

    modport slave (
        input  cfg_mode, cfg_alt_period, cfg_err_clr, hdr_ready, hdr_vs_in, out_vs_in,
        output hdr_en, hdr_sel, busy, switch_done, err_timeout
    );
endinterface

// File: rtl/hdr_mode_scheduler_vs_edge_det.sv
// Registered vsync with rising-edge pulse. The register resets to 1 so an
// idle-high vsync produces no edge on reset release.
module vs_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    output logic rise
);
    logic vs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vs_d <= 1'b1;
        else        vs_d <= vs;
    end

    assign rise = ~vs_d & vs;
endmodule

// File: rtl/hdr_mode_scheduler.sv
// HDR path switch sequencer: warm the HDR pipeline up over whole frames before
// selecting it, drain the mux before disabling it, with forced/auto modes.
module hdr_mode_scheduler
    import hdr_mode_scheduler_pkg::*;
#(
    parameter int WARM_FRAMES  = 2,
    parameter int DRAIN_FRAMES = 2,
    parameter int TIMEOUT_CYC  = 1 << 24
) (
    input  logic               pix_clk,
    input  logic               reset_n,
    hdr_mode_scheduler_if.slave bus
);
    localparam int               TO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [FRM_W-1:0] WARM_N  = FRM_W'(WARM_FRAMES);
    localparam logic [FRM_W-1:0] DRAIN_N = FRM_W'(DRAIN_FRAMES);

    state_t           state, state_n;
    logic             hdr_rise, out_rise;
    logic [1:0]       mode;
    logic             want_hdr;
    logic [FRM_W-1:0] alt_cnt, alt_last;
    logic             alt_phase;
    logic [FRM_W-1:0] frm_cnt, frm_n, frm_sat;
    logic             frm_inc;
    logic [TO_W-1:0]  to_cnt, to_n;
    logic             to_hit, done_n, retry_blk;

    vs_edge_det u_hdr_vs (.clk(pix_clk), .rst_n(reset_n), .vs(bus.hdr_vs_in), .rise(hdr_rise));
    vs_edge_det u_out_vs (.clk(pix_clk), .rst_n(reset_n), .vs(bus.out_vs_in), .rise(out_rise));

    assign mode     = (bus.cfg_mode == MODE_RSVD) ? MODE_NHDR : bus.cfg_mode;
    assign want_hdr = (mode == MODE_HDR) | ((mode == MODE_ALT) & alt_phase);
    assign alt_last = (bus.cfg_alt_period == 8'd0) ? 8'd0 : bus.cfg_alt_period - 8'd1;

    // >= rather than == so a period shrunk mid-phase still wraps promptly
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            alt_cnt   <= '0;
            alt_phase <= 1'b0;
        end else if (mode != MODE_ALT) begin
            alt_cnt   <= '0;
            alt_phase <= 1'b0;
        end else if (out_rise) begin
            if (alt_cnt >= alt_last) begin
                alt_cnt   <= '0;
                alt_phase <= ~alt_phase;
            end else begin
                alt_cnt <= alt_cnt + 8'd1;
            end
        end
    end

    // Count includes this cycle's edge so the transition lands on the next clock.
    assign frm_inc = (state == HDR_WARMUP) ? (hdr_rise & bus.hdr_ready) : out_rise;
    assign frm_sat = (frm_cnt == 8'hFF) ? frm_cnt : frm_cnt + {7'd0, frm_inc};

    always_comb begin
        state_n = state;
        frm_n   = frm_cnt;
        to_n    = to_cnt;
        to_hit  = 1'b0;
        done_n  = 1'b0;
        case (state)
            NHDR_ACTIVE: begin
                if (want_hdr && !retry_blk) begin
                    state_n = HDR_WARMUP;
                    frm_n   = '0;
                    to_n    = '0;
                end
            end
            HDR_WARMUP: begin
                frm_n = bus.hdr_ready ? frm_sat : '0;
                to_n  = to_cnt + 1'b1;
                if (!want_hdr) begin
                    state_n = NHDR_ACTIVE;
                    done_n  = 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    state_n = NHDR_ACTIVE;
                    to_hit  = 1'b1;
                end else if (bus.hdr_ready && frm_sat == WARM_N) begin
                    state_n = HDR_ACTIVE;
                    done_n  = 1'b1;
                end
            end
            HDR_ACTIVE: begin
                if (!want_hdr) begin
                    state_n = HDR_DRAIN;
                    frm_n   = '0;
                end
            end
            HDR_DRAIN: begin
                frm_n = frm_sat;
                if (want_hdr) begin
                    state_n = HDR_ACTIVE;
                    done_n  = 1'b1;
                end else if (frm_sat == DRAIN_N) begin
                    state_n = NHDR_ACTIVE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = NHDR_ACTIVE;
        endcase
    end

    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= NHDR_ACTIVE;
            frm_cnt         <= '0;
            to_cnt          <= '0;
            bus.hdr_en      <= 1'b0;
            bus.hdr_sel     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.switch_done <= 1'b0;
        end else begin
            state           <= state_n;
            frm_cnt         <= frm_n;
            to_cnt          <= to_n;
            bus.hdr_en      <= (state_n != NHDR_ACTIVE);
            bus.hdr_sel     <= (state_n == HDR_ACTIVE);
            bus.busy        <= (state_n == HDR_WARMUP) || (state_n == HDR_DRAIN);
            bus.switch_done <= done_n;
        end
    end

    // After a timeout, hold off re-entry until want_hdr has been seen low.
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            retry_blk       <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            if (to_hit)         retry_blk <= 1'b1;
            else if (!want_hdr) retry_blk <= 1'b0;
            if (to_hit)               bus.err_timeout <= 1'b1;
            else if (bus.cfg_err_clr) bus.err_timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hdr_mode_scheduler.sv
// Scoreboard bench for hdr_mode_scheduler: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_hdr_mode_scheduler;
    logic pix_clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // expectation bits: {hdr_en, hdr_sel, busy, switch_done, err_timeout}
    typedef struct {
        int         cyc;
        string      nm;
        logic [4:0] mask;
        logic [4:0] val;
    } exp_t;
    exp_t sb[$];

    hdr_mode_scheduler_if bus ();

    hdr_mode_scheduler #(
        .WARM_FRAMES (2),
        .DRAIN_FRAMES(2),
        .TIMEOUT_CYC (100)
    ) dut (
        .pix_clk(pix_clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 pix_clk = ~pix_clk;
    always @(posedge pix_clk) cyc++;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge pix_clk);
    endtask

    task automatic expect_at(input int off, input string nm, input logic [4:0] mask,
                             input logic [4:0] val);
        exp_t e;
        e.cyc  = cyc + off;
        e.nm   = nm;
        e.mask = mask;
        e.val  = val;
        sb.push_back(e);
    endtask

    // one vsync frame: low for a cycle, then high; the rise is sampled next edge
    task automatic pulse(input bit do_hdr, input bit do_out);
        tick();
        if (do_hdr) bus.hdr_vs_in = 1'b0;
        if (do_out) bus.out_vs_in = 1'b0;
        tick();
        if (do_hdr) bus.hdr_vs_in = 1'b1;
        if (do_out) bus.out_vs_in = 1'b1;
    endtask

    always @(negedge pix_clk) begin
        logic [4:0] obs;
        obs = {bus.hdr_en, bus.hdr_sel, bus.busy, bus.switch_done, bus.err_timeout};
        if (bus.hdr_sel && !bus.hdr_en) begin
            miscompares++;
            $display("FAIL sel_without_en cyc=%0d hdr_sel=1 hdr_en=0", cyc);
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                vectors++;
                if ((obs & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
                    miscompares++;
                    $display("FAIL %s cyc=%0d got=%b want=%b mask=%b (en,sel,busy,done,err)",
                             sb[i].nm, cyc, obs, sb[i].val, sb[i].mask);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                miscompares++;
                $display("FAIL %s cyc=%0d never checked", sb[i].nm, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_mode       = 2'd1;
        bus.cfg_alt_period = 8'd0;
        bus.cfg_err_clr    = 1'b0;
        bus.hdr_ready      = 1'b1;
        bus.hdr_vs_in      = 1'b1;
        bus.out_vs_in      = 1'b1;

        // reset state, then forced HDR entry and warm-up
        tick();
        expect_at(1, "reset", 5'b11111, 5'b00000);
        tick(2);
        reset_n = 1'b1;
        expect_at(1, "t1_en", 5'b11111, 5'b10100);
        pulse(1, 0);
        expect_at(1, "t1_warm1", 5'b11111, 5'b10100);
        pulse(1, 0);
        expect_at(1, "t1_sel", 5'b11111, 5'b11010);
        expect_at(2, "t1_done1", 5'b11111, 5'b11000);
        pulse(1, 0);
        expect_at(1, "t1_frame3", 5'b11111, 5'b11000);
        tick(2);

        // forced exit through drain
        bus.cfg_mode = 2'd0;
        expect_at(1, "t2_desel", 5'b11111, 5'b10100);
        pulse(0, 1);
        expect_at(1, "t2_drain1", 5'b11111, 5'b10100);
        pulse(0, 1);
        expect_at(1, "t2_nhdr", 5'b11111, 5'b00010);
        expect_at(2, "t2_idle", 5'b11111, 5'b00000);
        tick(2);

        // drain interrupted by re-request, then warm-up abort
        bus.cfg_mode = 2'd1;
        expect_at(1, "t3_warm", 5'b11111, 5'b10100);
        pulse(1, 0);
        pulse(1, 0);
        expect_at(1, "t3_sel", 5'b11111, 5'b11010);
        tick();
        bus.cfg_mode = 2'd0;
        expect_at(1, "t3_drain", 5'b11111, 5'b10100);
        pulse(0, 1);
        expect_at(1, "t3_drain1", 5'b11111, 5'b10100);
        tick();
        bus.cfg_mode = 2'd1;
        expect_at(1, "t3_redrive", 5'b11111, 5'b11010);
        tick(2);
        bus.cfg_mode = 2'd0;
        pulse(0, 1);
        pulse(0, 1);
        expect_at(1, "t3_nhdr", 5'b11111, 5'b00010);
        tick(2);
        bus.cfg_mode = 2'd1;
        expect_at(1, "t3_warm2", 5'b11111, 5'b10100);
        tick();
        bus.cfg_mode = 2'd0;
        expect_at(1, "t3_abort", 5'b11111, 5'b00010);
        expect_at(2, "t3_abort_idle", 5'b11111, 5'b00000);
        tick(2);

        // warm-up timeout with hdr_ready low
        bus.hdr_ready = 1'b0;
        bus.cfg_mode  = 2'd1;
        for (int k = 1; k <= 100; k++) expect_at(k, "t4_warm", 5'b11010, 5'b10000);
        expect_at(101, "t4_timeout", 5'b11111, 5'b00001);
        tick(101);
        for (int k = 1; k <= 3; k++) expect_at(k, "t4_blocked", 5'b11111, 5'b00001);
        tick(3);
        bus.cfg_err_clr = 1'b1;
        expect_at(1, "t4_clr", 5'b00001, 5'b00000);
        tick();
        bus.cfg_err_clr = 1'b0;
        bus.cfg_mode    = 2'd0;
        tick();
        bus.cfg_mode = 2'd1;
        expect_at(1, "t4_retry", 5'b11111, 5'b10100);
        tick();
        bus.cfg_mode  = 2'd0;
        bus.hdr_ready = 1'b1;
        expect_at(1, "t4_retry_abort", 5'b11111, 5'b00010);
        tick(2);

        // auto-alternate, period 3, both vsyncs aligned
        bus.cfg_mode       = 2'd2;
        bus.cfg_alt_period = 8'd3;
        pulse(1, 1);
        expect_at(1, "t5_f1", 5'b11111, 5'b00000);
        pulse(1, 1);
        expect_at(1, "t5_f2", 5'b11111, 5'b00000);
        pulse(1, 1);
        expect_at(1, "t5_f3", 5'b11111, 5'b00000);
        expect_at(2, "t5_warm", 5'b11111, 5'b10100);
        pulse(1, 1);
        expect_at(1, "t5_f4", 5'b11111, 5'b10100);
        pulse(1, 1);
        expect_at(1, "t5_sel", 5'b11111, 5'b11010);
        pulse(1, 1);
        expect_at(1, "t5_f6_hold", 5'b11111, 5'b11000);
        expect_at(2, "t5_f6_drain", 5'b11111, 5'b10100);
        pulse(1, 1);
        expect_at(1, "t5_f7", 5'b11111, 5'b10100);
        pulse(1, 1);
        expect_at(1, "t5_nhdr", 5'b11111, 5'b00010);
        pulse(1, 1);
        expect_at(1, "t5_f9", 5'b11111, 5'b00000);
        expect_at(2, "t5_warm2", 5'b11111, 5'b10100);
        pulse(1, 1);
        expect_at(1, "t5_f10", 5'b11111, 5'b10100);
        pulse(1, 1);
        expect_at(1, "t5_sel2", 5'b11111, 5'b11010);
        pulse(1, 1);
        expect_at(1, "t5_f12_hold", 5'b11111, 5'b11000);
        expect_at(2, "t5_f12_drain", 5'b11111, 5'b10100);
        tick(2);
        bus.cfg_mode = 2'd1;
        expect_at(1, "t5_redrive", 5'b11111, 5'b11010);
        tick(2);

        // asynchronous reset mid HDR_ACTIVE
        bus.hdr_vs_in = 1'b0;
        @(posedge pix_clk);
        #2;
        reset_n = 1'b0;
        expect_at(0, "t6_async", 5'b11111, 5'b00000);
        tick(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) expect_at(k, "t6_rel", 5'b11111, 5'b10100);
        tick(3);
        pulse(1, 0);
        expect_at(1, "t6_warm1", 5'b11111, 5'b10100);
        pulse(1, 0);
        expect_at(1, "t6_sel", 5'b11111, 5'b11010);
        tick(2);

        // no spurious out_vs edge on release with idle-high vsync
        reset_n            = 1'b0;
        bus.cfg_mode       = 2'd2;
        bus.cfg_alt_period = 8'd1;
        bus.out_vs_in      = 1'b1;
        bus.hdr_vs_in      = 1'b1;
        tick(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) expect_at(k, "t6_no_edge", 5'b11111, 5'b00000);
        tick(4);
        pulse(0, 1);
        expect_at(1, "t6_alt1", 5'b11111, 5'b00000);
        expect_at(2, "t6_alt_warm", 5'b11111, 5'b10100);
        tick(4);

        foreach (sb[i]) begin
            miscompares++;
            $display("FAIL %s cyc=%0d left unchecked", sb[i].nm, sb[i].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hdr_mode_scheduler.md
# hdr_mode_scheduler

Sequences switching between the HDR and non-HDR video paths ahead of `output_mux`. It enables the HDR pipeline, waits for it to warm up over whole frames, and only then drives `hdr_sel`. On the way out it drains the mux before disabling the pipeline. It supports forced modes and a frame-counted auto-alternate mode, and reports status and warm-up timeout to the register bank.

## Interface
- `WARM_FRAMES`, 2: HDR-path frames (`hdr_vs_in` rising edges) required after `hdr_ready` before selecting HDR
- `DRAIN_FRAMES`, 2: output frames (`out_vs_in` rising edges) after deselecting HDR before dropping `hdr_en`
- `TIMEOUT_CYC`, 2^24: max cycles in HDR_WARMUP before abort
- `pix_clk` in 1: pixel clock, single clock domain
- `reset_n` in 1: asynchronous, active-low reset
- `cfg_mode` in 2: 0 = force non-HDR, 1 = force HDR, 2 = auto-alternate, 3 = reserved (treated as 0)
- `cfg_alt_period` in 8: frames per phase in auto mode; 0 treated as 1
- `cfg_err_clr` in 1: single-cycle pulse, clears `err_timeout`
- `hdr_ready` in 1: level, HDR pipeline locked/valid
- `hdr_vs_in` in 1: HDR path vsync, idle-high
- `out_vs_in` in 1: `output_mux` `vs_o`
- `hdr_en` out 1: HDR pipeline enable
- `hdr_sel` out 1: drives `output_mux` `hdr_sel`
- `busy` out 1: high in HDR_WARMUP or HDR_DRAIN
- `switch_done` out 1: one-cycle pulse on entering HDR_ACTIVE or NHDR_ACTIVE, excluding the post-reset entry
- `err_timeout` out 1: sticky warm-up timeout flag

## Operation
- Edge detect: `hdr_vs_d` and `out_vs_d` registers reset to 1. Rising edge = `~d & in`, so no spurious edge leaves reset.
- `want_hdr` = (mode==1) | (mode==2 & alt_phase).
- `alt_phase` is held 0 when mode != 2. In mode 2 an 8-bit frame counter counts `out_vs_in` rising edges. When the count reaches max(`cfg_alt_period`,1)-1, the counter resets to 0 and `alt_phase` toggles. Leaving mode 2 clears both.
- FSM, 4 states:
  - NHDR_ACTIVE (reset state): `hdr_en`=0, `hdr_sel`=0. If `want_hdr`, go to HDR_WARMUP and clear the frame and timeout counters.
  - HDR_WARMUP: `hdr_en`=1, `hdr_sel`=0.
    - Frames count only `hdr_vs_in` rising edges while `hdr_ready`=1. `hdr_ready` falling resets the count to 0.
    - count==WARM_FRAMES → HDR_ACTIVE.
    - `!want_hdr` → NHDR_ACTIVE immediately; `hdr_sel` is never asserted.
    - Timeout counter reaches TIMEOUT_CYC-1 → NHDR_ACTIVE, set `err_timeout`, no `switch_done`. A new attempt starts only after `want_hdr` goes low and then high again.
  - HDR_ACTIVE: `hdr_en`=1, `hdr_sel`=1. `!want_hdr` → HDR_DRAIN, clear frame counter.
  - HDR_DRAIN: `hdr_en`=1, `hdr_sel`=0.
    - Count `out_vs_in` rising edges; count==DRAIN_FRAMES → NHDR_ACTIVE.
    - `want_hdr` rising again → HDR_ACTIVE directly. The pipeline is still warm and the mux handles its own abort.
- Priority within one cycle: want_hdr change > timeout > frame-count completion.
- `err_timeout`: set has priority over `cfg_err_clr` in the same cycle.

## Timing
- All outputs are registered and change on the same edge as the state register.
- Reset values: `hdr_en`=0, `hdr_sel`=0, `busy`=0, `switch_done`=0, `err_timeout`=0; state NHDR_ACTIVE.
- `cfg_mode` change to HDR entry: `hdr_en` high 1 cycle after `cfg_mode` is sampled.
- Warm-up completion: `hdr_sel` high 1 cycle after the cycle in which the WARM_FRAMES-th qualifying `hdr_vs_in` rising edge is visible.
- Frame counters saturate; they are 8 bits wide (WARM/DRAIN ≤ 255). The timeout counter is clog2(TIMEOUT_CYC) bits.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. `hdr_sel`=0 forces `output_mux` into non-HDR at its next frame boundary.
- `hdr_sel` never rises while `hdr_en`=0. `hdr_en` never falls while `hdr_sel`=1.

## Structure
- Shared video-ctrl package holds the state encoding localparams (NHDR_ACTIVE, HDR_WARMUP, HDR_ACTIVE, HDR_DRAIN) and the `cfg_mode` codes.
- One sub-module: `vs_edge_det` (registered vsync plus rising-edge pulse, reset-to-1). It is instantiated twice, for `hdr_vs_in` and `out_vs_in`.

## Test plan
- Reset with `cfg_mode`=1, `hdr_ready`=1, 3 `hdr_vs_in` frames → `hdr_en` at cycle 1 after release; `hdr_sel` 1 cycle after the 2nd rising edge; one `switch_done` pulse.
- In HDR_ACTIVE, `cfg_mode`=0 → `hdr_sel`=0 next cycle; `hdr_en` stays 1 until 1 cycle after the 2nd `out_vs_in` rising edge; `switch_done` on NHDR entry.
- `cfg_mode`=2, `cfg_alt_period`=3 → `hdr_sel` toggles only at frame boundaries. HDR intervals are exactly 3 output frames (with DRAIN_FRAMES=2) after the first warm-up.
- `hdr_ready`=0 throughout, TIMEOUT_CYC=100 → return to NHDR at cycle 100 of warm-up, `err_timeout`=1, no `switch_done`; a `cfg_err_clr` pulse clears it.
- In HDR_DRAIN after 1 frame, `cfg_mode`=1 → HDR_ACTIVE next cycle, `hdr_en` never drops. In HDR_WARMUP, `cfg_mode`=0 → `hdr_en`=0 next cycle, `hdr_sel` never pulses.
- Assert `reset_n`=0 mid HDR_ACTIVE → `hdr_sel`, `hdr_en`, `busy` low asynchronously; after release there is no spurious edge even if `hdr_vs_in`=0.
